branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Branch resolution block that produces the redirect pair consumed by the program counter: `PCSrc` (select branch) and `calcBranch` (target address). It sits in the execute stage. It holds the architectural NZCV flag register and evaluates B, BL, B.cond, CBZ, CBNZ and BR. It sequences the wrong-path flush of the IF and ID stages after every taken redirect.

## Interface
Parameters:
- `ADDR_W`, 64: address and data width.
- `FLUSH_CYC`, 2: number of cycles `flush` stays asserted per taken redirect (minimum 1).

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low; state is reset on a rising edge where `rst`=0.
- `br_valid` input 1: a branch-class instruction is present in the resolve stage this cycle.
- `br_type` input 3: branch kind, from the `br_type_e` encoding in the package.
- `cond` input 4: condition code for B.cond, standard ARM encoding.
- `pc_in` input ADDR_W: PC of the branch instruction.
- `imm_off` input ADDR_W: sign-extended byte offset, already shifted left by 2.
- `reg_val` input ADDR_W: forwarded register operand (Rt for CBZ/CBNZ, Rn for BR).
- `set_flags` input 1: the instruction producing `alu_flags` this cycle is a flag-setting op.
- `alu_flags` input 4: {N,Z,C,V} from the ALU.
- `stall` input 1: hazard stall; the resolve stage holds.
- `PCSrc` output 1: registered; 1 means the PC takes `calcBranch` at the next edge.
- `calcBranch` output ADDR_W: registered redirect target.
- `flush` output 1: registered; squashes the IF/ID pipeline registers.
- `flags_q` output 4: architectural NZCV register.

## Operation
- Effective flags: `flags_eff` = `set_flags ? alu_flags : flags_q`. This is same-cycle forwarding for an adjacent flag setter.
- Flag register update: when `set_flags`=1 and `stall`=0, then `flags_q` <= `alu_flags`.
- Taken rules:
  - B, BL: always taken.
  - BCOND: `cond_pass(cond, flags_eff)`. EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL and NV always taken.
  - CBZ: `reg_val`==0. CBNZ: `reg_val`!=0.
  - BR: always taken.
  - NONE: never taken.
- Target: BR uses `reg_val`. Every other type uses `pc_in + imm_off`, wrapping modulo 2^ADDR_W with no overflow detection.
- A branch is accepted when `br_valid`=1, `stall`=0 and the FSM is in IDLE.
- FSM states:
  - IDLE → REDIRECT on an accepted branch that is taken. An accepted branch that is not taken stays in IDLE.
  - REDIRECT → FLUSH when `FLUSH_CYC` > 1; otherwise REDIRECT → IDLE.
  - FLUSH: a counter runs down; → IDLE when it expires.
- `br_valid` in REDIRECT or FLUSH belongs to a wrong-path instruction. It is ignored: no redirect and no flag update. `set_flags` is likewise ignored in those states.
- `stall` does not freeze the FSM or the flush counter. Flush has priority over stall.
- BL link address is not produced here; it comes from the PC block's `pc_plus4`.

## Timing
- Reset values: `PCSrc`=0, `calcBranch`=0, `flush`=0, `flags_q`=4'b0000, FSM=IDLE, counter=0.
- Latency: a branch accepted at edge k gives `PCSrc`=1 and a valid `calcBranch` during cycle k+1, for exactly one cycle. The PC loads the target at edge k+2.
- `flush` is high for cycles k+1 … k+FLUSH_CYC.
- `calcBranch` holds its last value when `PCSrc`=0.
- Back-to-back taken branches: the second is in the flush window and is dropped.
- `rst`=0 mid-redirect or mid-flush: all outputs return to reset values at that edge, and the redirect in flight is lost.
- `set_flags` together with a BCOND in the same cycle: the branch uses `alu_flags`, and `flags_q` also updates.

## Structure
- Package `branch_pkg`: the `br_type_e` enum (NONE=0, B=1, BL=2, BCOND=3, CBZ=4, CBNZ=5, BR=6), `cond` code localparams, the FSM state enum, and a `cond_pass` function.
- One sub-module, `cond_eval`: combinational evaluation of `cond` and `flags_eff` to produce `pass`. It is instantiated once.
- Target adder: reuses the team's 64-bit adder.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → all outputs 0. Then with `rst`=1 and `br_valid`=0 → outputs stay 0.
- B: `pc_in`=0x100, `imm_off`=0x40 → next cycle `PCSrc`=1, `calcBranch`=0x140. `flush`=1 for 2 cycles, then 0.
- B.cond with forwarding: `flags_q`=0000, same-cycle `set_flags`=1, `alu_flags`=0100 (Z), `cond`=EQ → taken and `flags_q`=0100. Repeat with `cond`=NE → not taken, `PCSrc` stays 0.
- CBZ/CBNZ/BR: CBZ with `reg_val`=0 → taken. CBNZ with `reg_val`=0 → not taken. BR with `reg_val`=0xDEAD_BEE0 → `calcBranch`=0xDEAD_BEE0.
- Shadow and wrap: taken B with `pc_in`=0xFFFF_FFFF_FFFF_FFFC and `imm_off`=8 → `calcBranch`=0x4. A second taken B one cycle later is ignored, and a `set_flags` during the flush window leaves `flags_q` unchanged.
- Stall and reset: `br_valid`=1 with `stall`=1 → no redirect. Assert `rst`=0 during the flush window → `flush` and `PCSrc` are 0 the next cycle.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve slice: branch kinds, ARM condition codes,
// FSM states and the condition-pass evaluation.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_BL    = 3'd2,
    BR_BCOND = 3'd3,
    BR_CBZ   = 3'd4,
    BR_CBNZ  = 3'd5,
    BR_BR    = 3'd6
  } br_type_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // flags are packed {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_HS: r = c;
      COND_LO: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c && !z;
      COND_LS: r = !c || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-stage branch bus: branch operands in, PC redirect / flush / NZCV out.
interface branch_resolve_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              br_valid;
  logic [2:0]        br_type;
  logic [3:0]        cond;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] imm_off;
  logic [ADDR_W-1:0] reg_val;
  logic              set_flags;
  logic [3:0]        alu_flags;
  logic              stall;
  logic              PCSrc;
  logic [ADDR_W-1:0] calcBranch;
  logic              flush;
  logic [3:0]        flags_q;

  modport master (
    output br_valid, br_type, cond, pc_in, imm_off, reg_val, set_flags, alu_flags, stall,
    input  PCSrc, calcBranch, flush, flags_q
  );

  modport slave (
    input  br_valid, br_type, cond, pc_in, imm_off, reg_val, set_flags, alu_flags, stall,
    output PCSrc, calcBranch, flush, flags_q
  );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational B.cond evaluator over the effective NZCV flags.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  always_comb begin
    pass = cond_pass(cond, flags);
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: owns NZCV, computes redirect target, and
// sequences the IF/ID flush after each taken redirect.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC > 1 ? FLUSH_CYC - 2 : 0);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        flags_r;
  logic              pcsrc_r;
  logic              flush_r;
  logic [ADDR_W-1:0] calc_r;

  br_type_e          btype;
  logic [3:0]        flags_eff;
  logic              pass;
  logic              taken;
  logic              accept;
  logic              flag_we;
  logic [ADDR_W-1:0] seq_target;
  logic [ADDR_W-1:0] target;

  cond_eval u_cond_eval (
    .cond  (bus.cond),
    .flags (flags_eff),
    .pass  (pass)
  );

  always_comb begin
    btype      = br_type_e'(bus.br_type);
    flags_eff  = bus.set_flags ? bus.alu_flags : flags_r;
    seq_target = bus.pc_in + bus.imm_off;
    target     = (btype == BR_BR) ? bus.reg_val : seq_target;
    // Wrong-path instructions in REDIRECT/FLUSH neither branch nor write flags.
    accept     = bus.br_valid && !bus.stall && (state == ST_IDLE);
    flag_we    = bus.set_flags && !bus.stall && (state == ST_IDLE);
    case (btype)
      BR_B, BR_BL, BR_BR: taken = 1'b1;
      BR_BCOND:           taken = pass;
      BR_CBZ:             taken = (bus.reg_val == '0);
      BR_CBNZ:            taken = (bus.reg_val != '0);
      default:            taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      flags_r <= '0;
      pcsrc_r <= 1'b0;
      flush_r <= 1'b0;
      calc_r  <= '0;
    end else begin
      if (flag_we) begin
        flags_r <= bus.alu_flags;
      end
      case (state)
        ST_IDLE: begin
          if (accept && taken) begin
            state   <= ST_REDIRECT;
            pcsrc_r <= 1'b1;
            flush_r <= 1'b1;
            calc_r  <= target;
          end
        end
        ST_REDIRECT: begin
          pcsrc_r <= 1'b0;
          if (FLUSH_CYC > 1) begin
            state <= ST_FLUSH;
            cnt   <= CNT_INIT;
          end else begin
            state   <= ST_IDLE;
            flush_r <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            state   <= ST_IDLE;
            flush_r <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.PCSrc      = pcsrc_r;
  assign bus.flush      = flush_r;
  assign bus.calcBranch = calc_r;
  assign bus.flags_q    = flags_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branch vectors push
// expected targets; a negedge monitor pops them and tracks the flush window.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned FLUSH_CYC = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];

  branch_resolve_unit_if #(.ADDR_W(ADDR_W)) bus ();

  branch_resolve_unit #(.ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    br_type_e    t;
    logic [3:0]  c;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] rv;
    logic        sf;
    logic [3:0]  af;
    logic        st;
    logic        tk;
    logic [63:0] tgt;
    logic [3:0]  ef;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input br_type_e t, input logic [3:0] c, input logic [63:0] pc,
                              input logic [63:0] imm, input logic [63:0] rv, input logic sf,
                              input logic [3:0] af, input logic st, input logic tk,
                              input logic [63:0] tgt, input logic [3:0] ef);
    vec_t v;
    v.t = t; v.c = c; v.pc = pc; v.imm = imm; v.rv = rv; v.sf = sf;
    v.af = af; v.st = st; v.tk = tk; v.tgt = tgt; v.ef = ef;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.br_valid  = 1'b0;
    bus.br_type   = BR_NONE;
    bus.cond      = 4'h0;
    bus.pc_in     = '0;
    bus.imm_off   = '0;
    bus.reg_val   = '0;
    bus.set_flags = 1'b0;
    bus.alu_flags = 4'h0;
    bus.stall     = 1'b0;
  endtask

  task automatic drive(input br_type_e t, input logic [3:0] c, input logic [63:0] pc,
                       input logic [63:0] imm, input logic [63:0] rv, input logic sf,
                       input logic [3:0] af, input logic st);
    bus.br_valid  = 1'b1;
    bus.br_type   = t;
    bus.cond      = c;
    bus.pc_in     = pc;
    bus.imm_off   = imm;
    bus.reg_val   = rv;
    bus.set_flags = sf;
    bus.alu_flags = af;
    bus.stall     = st;
  endtask

  // Monitor: pops one expected target per PCSrc pulse and tracks flush length.
  initial begin
    int unsigned rem;
    logic [63:0] e;
    rem = 0;
    forever begin
      @(negedge clk);
      if (bus.PCSrc === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect actual calcBranch=%h expected no redirect", bus.calcBranch);
        end else begin
          e = exp_q.pop_front();
          chk("calcBranch", bus.calcBranch, e);
        end
      end
      if (rst !== 1'b1) begin
        rem = 0;
      end else if (bus.PCSrc === 1'b1) begin
        chk("flush_start", 64'(bus.flush), 64'd1);
        rem = FLUSH_CYC - 1;
      end else if (rem > 0) begin
        chk("flush_hold", 64'(bus.flush), 64'd1);
        rem--;
      end else begin
        chk("flush_idle", 64'(bus.flush), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_PCSrc", 64'(bus.PCSrc), 64'd0);
    chk("rst_calcBranch", bus.calcBranch, 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_flags_q", 64'(bus.flags_q), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_PCSrc", 64'(bus.PCSrc), 64'd0);
    chk("idle_calcBranch", bus.calcBranch, 64'd0);

    //            type      cond     pc                     imm                    reg_val                sf    af    st    tk    target                 exp flags
    vq.push_back(mk(BR_B,     COND_EQ, 64'h100,  64'h40,                 64'h0,  1'b0, 4'h0, 1'b0, 1'b1, 64'h140,               4'h0));
    vq.push_back(mk(BR_BL,    COND_EQ, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'hFFC,               4'h0));
    vq.push_back(mk(BR_BCOND, COND_EQ, 64'h200,  64'h10,  64'h0, 1'b1, 4'h4, 1'b0, 1'b1, 64'h210, 4'h4));
    vq.push_back(mk(BR_BCOND, COND_NE, 64'h200,  64'h10,  64'h0, 1'b1, 4'h4, 1'b0, 1'b0, 64'h0,   4'h4));
    vq.push_back(mk(BR_BCOND, COND_EQ, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h4));
    vq.push_back(mk(BR_NONE,  COND_EQ, 64'h0,    64'h0,   64'h0, 1'b1, 4'h8, 1'b0, 1'b0, 64'h0,   4'h8));
    vq.push_back(mk(BR_BCOND, COND_MI, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h8));
    vq.push_back(mk(BR_BCOND, COND_PL, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h8));
    vq.push_back(mk(BR_BCOND, COND_GE, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h8));
    vq.push_back(mk(BR_BCOND, COND_LT, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h8));
    vq.push_back(mk(BR_BCOND, COND_LE, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h8));
    vq.push_back(mk(BR_NONE,  COND_EQ, 64'h0,    64'h0,   64'h0, 1'b1, 4'h2, 1'b0, 1'b0, 64'h0,   4'h2));
    vq.push_back(mk(BR_BCOND, COND_HS, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h2));
    vq.push_back(mk(BR_BCOND, COND_HI, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h2));
    vq.push_back(mk(BR_BCOND, COND_LS, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h2));
    vq.push_back(mk(BR_BCOND, COND_LO, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h2));
    vq.push_back(mk(BR_NONE,  COND_EQ, 64'h0,    64'h0,   64'h0, 1'b1, 4'h6, 1'b0, 1'b0, 64'h0,   4'h6));
    vq.push_back(mk(BR_BCOND, COND_HI, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h6));
    vq.push_back(mk(BR_BCOND, COND_LS, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h6));
    vq.push_back(mk(BR_BCOND, COND_GT, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h6));
    vq.push_back(mk(BR_NONE,  COND_EQ, 64'h0,    64'h0,   64'h0, 1'b1, 4'h9, 1'b0, 1'b0, 64'h0,   4'h9));
    vq.push_back(mk(BR_BCOND, COND_GE, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h9));
    vq.push_back(mk(BR_BCOND, COND_LT, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h9));
    vq.push_back(mk(BR_BCOND, COND_GT, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h9));
    vq.push_back(mk(BR_BCOND, COND_LE, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h9));
    vq.push_back(mk(BR_NONE,  COND_EQ, 64'h0,    64'h0,   64'h0, 1'b1, 4'h1, 1'b0, 1'b0, 64'h0,   4'h1));
    vq.push_back(mk(BR_BCOND, COND_VS, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h1));
    vq.push_back(mk(BR_BCOND, COND_VC, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h1));
    vq.push_back(mk(BR_NONE,  COND_EQ, 64'h0,    64'h0,   64'h0, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0,   4'h0));
    vq.push_back(mk(BR_BCOND, COND_AL, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h0));
    vq.push_back(mk(BR_BCOND, COND_NV, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h0));
    vq.push_back(mk(BR_BCOND, COND_NE, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h210, 4'h0));
    vq.push_back(mk(BR_BCOND, COND_EQ, 64'h200,  64'h10,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h0));
    vq.push_back(mk(BR_CBZ,   COND_EQ, 64'h300,  64'h20,  64'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h320, 4'h0));
    vq.push_back(mk(BR_CBZ,   COND_EQ, 64'h300,  64'h20,  64'h5, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h0));
    vq.push_back(mk(BR_CBNZ,  COND_EQ, 64'h300,  64'h20,  64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0,   4'h0));
    vq.push_back(mk(BR_CBNZ,  COND_EQ, 64'h300,  64'h20,  64'h5, 1'b0, 4'h0, 1'b0, 1'b1, 64'h320, 4'h0));
    vq.push_back(mk(BR_BR,    COND_EQ, 64'h300,  64'h20,  64'hDEAD_BEE0, 1'b0, 4'h0, 1'b0, 1'b1, 64'hDEAD_BEE0, 4'h0));
    vq.push_back(mk(BR_B,     COND_EQ, 64'h400,  64'h40,  64'h0, 1'b1, 4'hF, 1'b1, 1'b0, 64'h0,   4'h0));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(posedge clk); #1;
      drive(v.t, v.c, v.pc, v.imm, v.rv, v.sf, v.af, v.st);
      if (v.tk) exp_q.push_back(v.tgt);
      @(posedge clk); #1;
      idle_inputs();
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_pending", i), 64'(exp_q.size()), 64'd0);
      chk($sformatf("vec%0d_flags_q", i), 64'(bus.flags_q), 64'(v.ef));
    end

    // Wrapping target, then wrong-path branches and flag writes in the shadow.
    @(posedge clk); #1;
    drive(BR_B, COND_EQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0, 1'b0, 4'h0, 1'b0);
    exp_q.push_back(64'h4);
    @(posedge clk); #1;
    drive(BR_B, COND_EQ, 64'h0, 64'h500, 64'h0, 1'b1, 4'hF, 1'b0);
    @(posedge clk); #1;
    drive(BR_B, COND_EQ, 64'h0, 64'h600, 64'h0, 1'b1, 4'hA, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("shadow_pending", 64'(exp_q.size()), 64'd0);
    chk("shadow_flags_q", 64'(bus.flags_q), 64'd0);

    // Reset arriving inside the flush window.
    @(posedge clk); #1;
    drive(BR_B, COND_EQ, 64'h40, 64'h40, 64'h0, 1'b1, 4'h3, 1'b0);
    exp_q.push_back(64'h80);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_flush", 64'(bus.flush), 64'd0);
    chk("midrst_PCSrc", 64'(bus.PCSrc), 64'd0);
    chk("midrst_calcBranch", bus.calcBranch, 64'd0);
    chk("midrst_flags_q", 64'(bus.flags_q), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_pending", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
